// File: rtl/bus_arbiter_4c.sv
// bus_arbiter_4c: round-robin common-bus arbiter with proc/snoop grants for NUM_CORES cache wrappers.
// Optional watchdog release is built only when ARB_TIMEOUT_EN is defined.
module bus_arbiter_4c #(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CORES-1:0] Com_Bus_Req_proc,
  input  logic [NUM_CORES-1:0] Com_Bus_Req_snoop,
  output logic [NUM_CORES-1:0] Com_Bus_Gnt_proc,
  output logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop,
  input  logic [NUM_CORES-1:0] Shared_local,
  output logic                 Shared,
  input  logic [NUM_CORES-1:0] Invalidation_done,
  output logic                 All_Invalidation_done,
  output logic [1:0]           Owner,
  output logic                 Arb_timeout
);

  localparam int IW = 2;

  if (NUM_CORES < 2 || NUM_CORES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bus_arbiter_4c: NUM_CORES must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, PROC, SNOOP, RELEASE} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        snoop_ptr_q, snoop_ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        snooper_q, snooper_d;
  logic [NUM_CORES-1:0] gnt_proc_q, gnt_proc_d;
  logic [NUM_CORES-1:0] gnt_snoop_q, gnt_snoop_d;
  logic [IW:0]          pick_proc, pick_snoop;
  logic                 busy;
  logic                 timeout;

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                          input logic [IW-1:0]        ptr);
    logic [IW:0] pick;
    int unsigned idx;
    pick = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      idx = (32'(ptr) + i) % 32'(NUM_CORES);
      if (!pick[IW] && req[IW'(idx)]) pick = {1'b1, IW'(idx)};
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (32'(idx) == 32'(NUM_CORES - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign busy = (state_q == PROC) || (state_q == SNOOP);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  always_comb wd_cnt_d = busy ? wd_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end

  // Counter holds (grant cycle - 1), so this fires in grant cycle TIMEOUT_CYCLES.
  assign timeout = busy && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    snoop_ptr_d = snoop_ptr_q;
    owner_d     = owner_q;
    snooper_d   = snooper_q;
    gnt_proc_d  = gnt_proc_q;
    gnt_snoop_d = gnt_snoop_q;
    pick_proc   = rr_pick(Com_Bus_Req_proc, rr_ptr_q);
    pick_snoop  = rr_pick(Com_Bus_Req_snoop & ~gnt_proc_q, snoop_ptr_q);
    case (state_q)
      IDLE, RELEASE: begin
        // RELEASE arbitrates with the already-advanced rr_ptr, keeping the bus gap to one cycle.
        state_d     = IDLE;
        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        if (pick_proc[IW]) begin
          state_d    = PROC;
          owner_d    = pick_proc[IW-1:0];
          gnt_proc_d = NUM_CORES'(1) << pick_proc[IW-1:0];
        end
      end
      PROC: begin
        if (timeout || !Com_Bus_Req_proc[owner_q]) begin
          state_d    = RELEASE;
          gnt_proc_d = '0;
          rr_ptr_d   = next_idx(owner_q);
        end else if (pick_snoop[IW]) begin
          state_d     = SNOOP;
          snooper_d   = pick_snoop[IW-1:0];
          gnt_snoop_d = NUM_CORES'(1) << pick_snoop[IW-1:0];
        end
      end
      SNOOP: begin
        if (timeout) begin
          state_d     = RELEASE;
          gnt_proc_d  = '0;
          gnt_snoop_d = '0;
          rr_ptr_d    = next_idx(owner_q);
        end else if (!Com_Bus_Req_snoop[snooper_q]) begin
          state_d     = PROC;
          gnt_snoop_d = '0;
          snoop_ptr_d = next_idx(snooper_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      snoop_ptr_q <= '0;
      owner_q     <= '0;
      snooper_q   <= '0;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      snoop_ptr_q <= snoop_ptr_d;
      owner_q     <= owner_d;
      snooper_q   <= snooper_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snoop_q <= gnt_snoop_d;
    end
  end

  assign Com_Bus_Gnt_proc      = gnt_proc_q;
  assign Com_Bus_Gnt_snoop     = gnt_snoop_q;
  assign Owner                 = busy ? owner_q : 2'b00;
  assign Shared                = busy && (|(Shared_local & ~gnt_proc_q));
  assign All_Invalidation_done = busy && (&(Invalidation_done | gnt_proc_q));
  assign Arb_timeout           = timeout;

endmodule

// File: tb/tb_bus_arbiter_4c.sv
// Scoreboard bench for bus_arbiter_4c: directed scenarios plus random traffic against a behavioural model.
module tb_bus_arbiter_4c;

  localparam int N = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_p = '0, req_s = '0, sh_l = '0, inv_d = '0;
  logic [N-1:0] gnt_p, gnt_s;
  logic         shared, all_inv, arb_to;
  logic [1:0]   owner;

  bus_arbiter_4c #(.NUM_CORES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .Com_Bus_Req_proc     (req_p),
    .Com_Bus_Req_snoop    (req_s),
    .Com_Bus_Gnt_proc     (gnt_p),
    .Com_Bus_Gnt_snoop    (gnt_s),
    .Shared_local         (sh_l),
    .Shared               (shared),
    .Invalidation_done    (inv_d),
    .All_Invalidation_done(all_inv),
    .Owner                (owner),
    .Arb_timeout          (arb_to)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gp;
    logic [3:0] gs;
    logic [1:0] own;
    logic       sh;
    logic       ai;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   errors = 0;
  int   checks = 0;
  bit   run    = 1'b0;
  bit   log_en = 1'b0;
  event rst_ev;

  // Reference model: -1 means "nobody"; a release cycle is simply a cycle with no owner.
  int m_owner = -1, m_snp = -1, m_rr = 0, m_sp = 0, m_age = 0;

  function automatic int find(logic [3:0] req, int ptr, int excl);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (c != excl && req[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_snp = -1; m_rr = 0; m_sp = 0; m_age = 0;
  endfunction

  function automatic void model_step(logic [3:0] rp, logic [3:0] rs);
    bit expire;
    expire = TO_EN && (m_owner >= 0) && (m_age == TO);
    if (m_owner < 0) begin
      m_snp   = -1;
      m_owner = find(rp, m_rr, -1);
      m_age   = 1;
    end else if (expire) begin
      m_rr    = (m_owner + 1) % N;
      m_owner = -1;
      m_snp   = -1;
    end else if (m_snp < 0) begin
      if (!rp[m_owner]) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_snp = find(rs, m_sp, m_owner);
        m_age++;
      end
    end else begin
      if (!rs[m_snp]) begin
        m_sp  = (m_snp + 1) % N;
        m_snp = -1;
      end
      m_age++;
    end
  endfunction

  function automatic void push_exp(logic [3:0] sl, logic [3:0] iv);
    exp_t       e;
    logic [3:0] om;
    om    = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    e.gp  = om;
    e.gs  = (m_snp >= 0) ? 4'(1 << m_snp) : 4'b0;
    e.own = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.sh  = (m_owner >= 0) && ((sl & ~om) != 4'b0);
    e.ai  = (m_owner >= 0) && ((iv | om) == 4'hF);
    e.to  = TO_EN && (m_owner >= 0) && (m_age == TO);
    sb.push_back(e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_one(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got gnt_proc=%b required an expected entry at %0t",
               tag, gnt_p, $time);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".gnt_proc"},  32'(gnt_p),   32'(e.gp));
    chk({tag, ".gnt_snoop"}, 32'(gnt_s),   32'(e.gs));
    chk({tag, ".owner"},     32'(owner),   32'(e.own));
    chk({tag, ".shared"},    32'(shared),  32'(e.sh));
    chk({tag, ".all_inv"},   32'(all_inv), 32'(e.ai));
    chk({tag, ".timeout"},   32'(arb_to),  32'(e.to));
  endtask

  initial begin : monitor
    logic [N-1:0] prev_gp;
    prev_gp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (run) begin
        compare_one("cycle");
        checks++;
        if (!$onehot0(gnt_p) || !$onehot0(gnt_s)) begin
          errors++;
          $display("FAIL onehot: got gnt_proc=%b gnt_snoop=%b required one-hot or zero", gnt_p, gnt_s);
        end
        if (log_en && gnt_p != '0 && gnt_p != prev_gp) begin
          for (int i = 0; i < N; i++) if (gnt_p[i]) grant_log.push_back(i);
        end
        prev_gp = gnt_p;
      end
    end
  end

  initial begin : async_monitor
    forever begin
      @(rst_ev);
      #1;
      compare_one("async_rst");
    end
  end

  task automatic step(logic [3:0] rp, logic [3:0] rs, logic [3:0] sl, logic [3:0] iv);
    @(negedge clk);
    rst = 1'b0; req_p = rp; req_s = rs; sh_l = sl; inv_d = iv;
    model_step(rp, rs);
    push_exp(sl, iv);
    run = 1'b1;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1; req_p = '0; req_s = '0; sh_l = '0; inv_d = '0;
    model_reset();
    push_exp('0, '0);
    run = 1'b1;
  endtask

  // Raises rst mid-cycle: grants must drop before the next clock edge.
  task automatic async_reset(logic [3:0] rp, logic [3:0] rs, logic [3:0] sl, logic [3:0] iv);
    @(negedge clk);
    req_p = rp; req_s = rs; sh_l = sl; inv_d = iv;
    #2;
    rst = 1'b1;
    model_reset();
    push_exp(sl, iv);
    ->rst_ev;
    push_exp(sl, iv);
  endtask

  initial begin : stimulus
    logic [3:0] rp, rs;
    int         exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state, then two requesters: lower index after rr_ptr=0 wins.
    hold_reset(); hold_reset();
    step(4'b0110, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0110, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0110, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Owner 0 with snoop traffic, own snoop bit ignored, owner drop during snoop.
    hold_reset();
    step(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0001, 4'b1011, 4'b0000, 4'b0000);
    step(4'b0001, 4'b1011, 4'b0000, 4'b0000);
    step(4'b0001, 4'b1001, 4'b0000, 4'b0000);
    step(4'b0001, 4'b1001, 4'b0000, 4'b0000);
    step(4'b0001, 4'b1001, 4'b0000, 4'b0000);
    step(4'b0000, 4'b1000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b1111, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Owner 2: Shared and All_Invalidation_done exclude the owner.
    hold_reset();
    step(4'b0100, 4'b0000, 4'b0100, 4'b0000);
    step(4'b0100, 4'b0000, 4'b0100, 4'b0000);
    step(4'b0100, 4'b0000, 4'b0101, 4'b1011);
    step(4'b0100, 4'b0000, 4'b0101, 4'b1001);
    step(4'b0000, 4'b0000, 4'b1111, 4'b1111);
    step(4'b0000, 4'b0000, 4'b1111, 4'b1111);

    // Owner 3 with core 0 snooping, then asynchronous reset.
    hold_reset();
    step(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b1000, 4'b0001, 4'b0000, 4'b0000);
    step(4'b1000, 4'b0001, 4'b0000, 4'b0000);
    async_reset(4'b1001, 4'b0001, 4'b0001, 4'b0000);
    step(4'b1001, 4'b0000, 4'b0000, 4'b0000);
    step(4'b1001, 4'b0000, 4'b0000, 4'b0000);

    // All cores requesting, each drops after 3 granted cycles.
    hold_reset();
    grant_log.delete();
    log_en = 1'b1;
    for (int c = 0; c < 24; c++) begin
      rp = 4'hF;
      if (m_owner >= 0 && m_age >= 3) rp[m_owner] = 1'b0;
      step(rp, 4'b0000, 4'b0000, 4'b0000);
    end
    log_en = 1'b0;

`ifdef ARB_TIMEOUT_EN
    hold_reset();
    for (int c = 0; c < 20; c++) step(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    for (int c = 0; c < 20; c++) step(4'b0110, 4'b0100, 4'b0000, 4'b0000);
`endif

    // Random sticky traffic with one asynchronous reset in the middle.
    hold_reset();
    rp = '0;
    rs = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if (rp[b]) rp[b] = ($urandom_range(0, 4) != 0);
        else       rp[b] = ($urandom_range(0, 2) == 0);
        if (rs[b]) rs[b] = ($urandom_range(0, 2) != 0);
        else       rs[b] = ($urandom_range(0, 3) == 0);
      end
      if (c == 200) async_reset(rp, rs, 4'($urandom), 4'($urandom));
      else          step(rp, rs, 4'($urandom), 4'($urandom));
    end

    @(posedge clk);
    #2;
    run = 1'b0;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("grant_order.count_ge5", 32'(grant_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) chk($sformatf("grant_order[%0d]", i), 32'(grant_log[i]), 32'(exp_order[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_4c.md
BUS_ARBITER_4C -- requirements
Module: bus_arbiter_4c

Interface
- REQ-001: Parameter `NUM_CORES`, default 4: number of cache_wrapper instances on the common bus.
- REQ-002: Parameter `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles; used only under `ARB_TIMEOUT_EN`.
- REQ-003: `clk`, input, 1: single clock; all state updates on the rising edge.
- REQ-004: `rst`, input, 1: asynchronous, active-high reset.
- REQ-005: `Com_Bus_Req_proc`, input, NUM_CORES: bit i is core i's processor-side bus request.
- REQ-006: `Com_Bus_Req_snoop`, input, NUM_CORES: bit i is core i's snoop-side bus request.
- REQ-007: `Com_Bus_Gnt_proc`, output, NUM_CORES: one-hot or zero processor-side grant.
- REQ-008: `Com_Bus_Gnt_snoop`, output, NUM_CORES: one-hot or zero snoop-side grant.
- REQ-009: `Shared_local`, input, NUM_CORES: bit i means core i holds a copy of the bus address.
- REQ-010: `Shared`, output, 1: OR of `Shared_local` over non-owner cores.
- REQ-011: `Invalidation_done`, input, NUM_CORES: bit i means core i has completed invalidation.
- REQ-012: `All_Invalidation_done`, output, 1: all non-owner cores have invalidated.
- REQ-013: `Owner`, output, 2: index of the current processor-grant holder; 0 when idle.
- REQ-014: `Arb_timeout`, output, 1: one-cycle pulse on watchdog release (`ARB_TIMEOUT_EN` only).

Function
- REQ-015: FSM states are IDLE, PROC, SNOOP and RELEASE.
- REQ-016: IDLE, any `Com_Bus_Req_proc` high → PROC next edge.
  - Grant goes to the first requester at or after `rr_ptr`, searching upward with wrap from 3 to 0.
  - Request-to-grant latency is exactly 1 cycle.
- REQ-017: PROC: grant is held while the owner's `Com_Bus_Req_proc` stays high. Owner request low → RELEASE next edge.
- REQ-018: PROC, any non-owner `Com_Bus_Req_snoop` high → SNOOP next edge. `Com_Bus_Gnt_proc` stays asserted.
  - Snoop grant goes round-robin from `snoop_ptr`, excluding the owner.
- REQ-019: SNOOP: snoop grant is held while that core's `Com_Bus_Req_snoop` stays high.
  - On deassert, next edge returns to PROC.
  - `snoop_ptr` becomes winner+1 (mod 4).
- REQ-020: Owner's proc request drops while in SNOOP: snoop grant completes first, then PROC → RELEASE.
- REQ-021: RELEASE: all grants are 0 for exactly 1 cycle; `rr_ptr` becomes owner+1 (mod 4); then IDLE.
- REQ-022: The owner's own `Com_Bus_Req_snoop` is ignored. Snoop requests in IDLE or RELEASE are ignored.
- REQ-023: At most one bit of `Com_Bus_Gnt_proc` and at most one bit of `Com_Bus_Gnt_snoop` are high in any cycle.
- REQ-024: All grants are registered outputs.
- REQ-025: `Shared` and `All_Invalidation_done` are combinational; both are 0 outside PROC/SNOOP.
- REQ-026: `All_Invalidation_done` = AND of `Invalidation_done` over the non-owner cores.
- REQ-027: Simultaneous proc requests: winner by `rr_ptr` order only; losers stay pending with no state kept.

Reset
- REQ-028: While `rst` is high, the following are forced to 0 asynchronously:
  - FSM = IDLE, `rr_ptr` = 0, `snoop_ptr` = 0;
  - all grants, `Owner`, `Arb_timeout`, `Shared`, `All_Invalidation_done`;
  - watchdog counter.
- REQ-029: Reset mid-PROC/SNOOP drops grants immediately with no RELEASE cycle.
- REQ-030: The first grant after reset deassertion is evaluated at the first rising edge with `rst` low.

Configuration
- REQ-031: Macro `ARB_TIMEOUT_EN` defined:
  - A counter increments each cycle in PROC/SNOOP and clears on entry to IDLE.
  - Reaching `TIMEOUT_CYCLES` forces RELEASE and pulses `Arb_timeout` for 1 cycle.
  - `rr_ptr` advances as normal.
- REQ-032: Macro not defined: no counter is built, `Arb_timeout` is tied 0, and grants are held indefinitely.

Verification
- REQ-033: After reset, `Com_Bus_Req_proc`=4'b0110 → cycle+1 `Com_Bus_Gnt_proc`=4'b0010, `Owner`=1.
  - Drop bit1 → 1 idle cycle, then `Com_Bus_Gnt_proc`=4'b0100.
- REQ-034: Owner 0 in PROC, `Com_Bus_Req_snoop`=4'b1011 → cycle+1 `Com_Bus_Gnt_snoop`=4'b0010 with `Com_Bus_Gnt_proc`=4'b0001 held.
  - Drop bit1 → PROC, then `Com_Bus_Gnt_snoop`=4'b1000.
- REQ-035: Owner 2, `Shared_local`=4'b0100 → `Shared`=0; `Shared_local`=4'b0101 → `Shared`=1.
  - `Invalidation_done`=4'b1011 → `All_Invalidation_done`=1.
- REQ-036: Owner 3 in SNOOP (core 0), `rst` pulsed high → all grants 0 in the same cycle; FSM IDLE; `rr_ptr`=0.
- REQ-037: `ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, owner 1 holds its request for 20 cycles:
  - `Arb_timeout` pulses at cycle 8 of grant;
  - 1-cycle gap follows;
  - core 2 is granted if requesting, otherwise core 1 is re-granted.
- REQ-038: All 4 cores request continuously, each dropping 3 cycles after grant → grant order 0,1,2,3,0; the one-hot assertion never fails.
